// File: rtl/bsg_lfsr_checker.sv
// LFSR pattern checker: self-synchronises to an incoming Galois LFSR word stream, then flags mismatched words.
// Latency: every update is visible one cycle after the acceptance cycle; lock/err/counters are all registered.
// Backpressure: none; ready_o is high whenever reset_i is low. Optional bit-error counter: BSG_LFSR_CHECKER_BIT_ERR_EN.
module bsg_lfsr_checker #(
  parameter int width_p = 16,
  parameter logic [width_p-1:0] taps_p = 16'hB400,
  parameter int lock_threshold_p = 4,
  parameter int unlock_threshold_p = 3,
  parameter int cnt_width_p = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   v_i,
  input  logic [width_p-1:0]     data_i,
  output logic                   ready_o,
  input  logic                   clear_i,
  output logic                   locked_o,
  output logic                   err_v_o,
  output logic [width_p-1:0]     err_mask_o,
  output logic [cnt_width_p-1:0] err_count_o,
`ifdef BSG_LFSR_CHECKER_BIT_ERR_EN
  output logic [cnt_width_p-1:0] bit_err_count_o,
`endif
  output logic [cnt_width_p-1:0] word_count_o
);

  localparam int match_w = $clog2(lock_threshold_p + 1);
  localparam int miss_w  = $clog2(unlock_threshold_p + 1);
  localparam logic [match_w-1:0] lock_thr_lp   = match_w'(lock_threshold_p);
  localparam logic [miss_w-1:0]  unlock_thr_lp = miss_w'(unlock_threshold_p);
  localparam logic [cnt_width_p-1:0] cnt_one_lp = cnt_width_p'(1);

  typedef enum logic {SEEK = 1'b0, LOCKED = 1'b1} state_e;

  state_e                 state_r, state_n;
  logic [width_p-1:0]     expected_r, expected_n;
  logic [match_w-1:0]     match_cnt_r, match_cnt_n;
  logic [miss_w-1:0]      miss_cnt_r, miss_cnt_n;
  logic                   err_v_r, err_v_n;
  logic [width_p-1:0]     err_mask_r, err_mask_n;
  logic [cnt_width_p-1:0] err_count_r, err_count_n;
  logic [cnt_width_p-1:0] word_count_r, word_count_n;

  logic                   accept;
  logic [width_p-1:0]     diff;
  logic                   match;

  // One Galois LFSR advance.
  function automatic logic [width_p-1:0] step(input logic [width_p-1:0] x);
    return (x >> 1) ^ (x[0] ? taps_p : '0);
  endfunction

  assign ready_o  = ~reset_i;
  assign accept   = v_i & ready_o;
  assign diff     = data_i ^ expected_r;
  assign match    = &(~diff);

  assign locked_o     = (state_r == LOCKED);
  assign err_v_o      = err_v_r;
  assign err_mask_o   = err_mask_r;
  assign err_count_o  = err_count_r;
  assign word_count_o = word_count_r;

  // Next-state: seeding/lock acquisition in SEEK, checking and lock loss in LOCKED.
  always_comb begin
    state_n      = state_r;
    expected_n   = expected_r;
    match_cnt_n  = match_cnt_r;
    miss_cnt_n   = miss_cnt_r;
    err_v_n      = 1'b0;
    err_mask_n   = err_mask_r;
    err_count_n  = err_count_r;
    word_count_n = word_count_r;
    if (accept) begin
      if (state_r == SEEK) begin
        if (data_i == '0) begin
          // An all-zero word is a dead LFSR state and can never seed.
          match_cnt_n = '0;
        end else begin
          if ((match_cnt_r != '0) && match) match_cnt_n = match_cnt_r + match_w'(1);
          else                              match_cnt_n = match_w'(1);
          expected_n = step(data_i);
        end
        if ((data_i != '0) && (match_cnt_n == lock_thr_lp)) begin
          state_n    = LOCKED;
          miss_cnt_n = '0;
        end
      end else begin
        // Once locked the expectation free-runs; data never reseeds it.
        expected_n   = step(expected_r);
        word_count_n = (&word_count_r) ? word_count_r : word_count_r + cnt_one_lp;
        if (match) begin
          miss_cnt_n = '0;
        end else begin
          err_v_n     = 1'b1;
          err_mask_n  = diff;
          err_count_n = (&err_count_r) ? err_count_r : err_count_r + cnt_one_lp;
          miss_cnt_n  = miss_cnt_r + miss_w'(1);
          if (miss_cnt_n == unlock_thr_lp) begin
            state_n     = SEEK;
            match_cnt_n = '0;
          end
        end
      end
    end
    if (clear_i) begin
      err_count_n  = '0;
      word_count_n = '0;
    end
  end

  // State, expectation, error outputs and counters.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r      <= SEEK;
      expected_r   <= '0;
      match_cnt_r  <= '0;
      miss_cnt_r   <= '0;
      err_v_r      <= 1'b0;
      err_mask_r   <= '0;
      err_count_r  <= '0;
      word_count_r <= '0;
    end else begin
      state_r      <= state_n;
      expected_r   <= expected_n;
      match_cnt_r  <= match_cnt_n;
      miss_cnt_r   <= miss_cnt_n;
      err_v_r      <= err_v_n;
      err_mask_r   <= err_mask_n;
      err_count_r  <= err_count_n;
      word_count_r <= word_count_n;
    end
  end

`ifdef BSG_LFSR_CHECKER_BIT_ERR_EN
  localparam int pop_w = $clog2(width_p + 1);
  localparam int sum_w = ((cnt_width_p > pop_w) ? cnt_width_p : pop_w) + 1;
  localparam logic [sum_w-1:0] sat_lp = sum_w'({cnt_width_p{1'b1}});

  logic [cnt_width_p-1:0] bit_err_count_r;
  logic [sum_w-1:0]       bit_sum;

  function automatic logic [pop_w-1:0] popcount(input logic [width_p-1:0] x);
    logic [pop_w-1:0] c;
    c = '0;
    for (int i = 0; i < width_p; i++) c = c + pop_w'(x[i]);
    return c;
  endfunction

  assign bit_sum         = sum_w'(bit_err_count_r) + sum_w'(popcount(diff));
  assign bit_err_count_o = bit_err_count_r;

  // Accumulate errored bits of mismatched locked words, saturating at all-ones.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bit_err_count_r <= '0;
    end else if (clear_i) begin
      bit_err_count_r <= '0;
    end else if (accept && (state_r == LOCKED) && !match) begin
      bit_err_count_r <= (bit_sum > sat_lp) ? {cnt_width_p{1'b1}} : bit_sum[cnt_width_p-1:0];
    end
  end
`endif

endmodule

// File: doc/bsg_lfsr_checker.md
Name: bsg_lfsr_checker

Overview:
- Receive-side checker for an LFSR test-pattern stream: the consuming end of a pattern generator on a link, FIFO or channel under test.
- Self-synchronises to the incoming words, then compares every accepted word against the expected word with a bitwise XNOR match.
- Reports lock state, per-word error pulses and mismatch masks, and saturating error and word counters.
- Sits at the sink of loopback and bring-up test paths.

Parameters:
- width_p, 16, data word width in bits.
- taps_p, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1); width width_p.
- lock_threshold_p, 4, consecutive sequence-consistent words (seed included) required to lock; legal range 2 or more.
- unlock_threshold_p, 3, consecutive mismatched words in LOCKED that drop lock; legal range 1 or more.
- cnt_width_p, 16, width of all counters.

Ports:
- clk_i, input, 1, clock.
- reset_i, input, 1, asynchronous active-high reset.
- v_i, input, 1, data_i valid.
- data_i, input, width_p, received word.
- ready_o, input-side handshake, output, 1, always 1 when reset_i is low; a word is accepted when v_i and ready_o are both high.
- clear_i, input, 1, synchronous clear of all counters; does not change lock state.
- locked_o, output, 1, high in LOCKED.
- err_v_o, output, 1, one-cycle pulse for a mismatched word accepted in LOCKED.
- err_mask_o, output, width_p, mismatch bits of the most recent erroneous word; 1 = bit differs.
- err_count_o, output, cnt_width_p, erroneous words seen in LOCKED; saturating.
- word_count_o, output, cnt_width_p, words accepted in LOCKED; saturating.
- bit_err_count_o, output, cnt_width_p, errored bits seen; present only with the optional feature.

Behaviour:
- step(x) = (x >> 1) ^ (x[0] ? taps_p : 0).
- match = &(~(data_i ^ expected_r)), a bitwise XNOR reduction.
- All outputs are registered. Every update is visible the cycle after the acceptance cycle.
- Reset (asynchronous, active-high):
  - state = SEEK; expected_r, match_cnt and miss_cnt = 0.
  - All outputs 0, except ready_o, which is 0 while reset_i is high.
- SEEK, per accepted word d:
  - If d == 0: match_cnt = 0 and expected_r is unchanged (an all-zero word is never a seed).
  - Else if match_cnt > 0 and match: match_cnt += 1.
  - Otherwise: match_cnt = 1 (d becomes the new seed).
  - In both nonzero cases: expected_r = step(d).
  - When the updated match_cnt equals lock_threshold_p: go to LOCKED, set miss_cnt = 0, and assert locked_o the next cycle.
  - No error outputs or counters change in SEEK.
- LOCKED, per accepted word:
  - expected_r = step(expected_r). Data never reseeds the expectation.
  - word_count += 1.
  - On match: miss_cnt = 0.
  - On mismatch:
    - err_v_o pulses for one cycle.
    - err_mask_o = data_i ^ expected_r.
    - err_count += 1.
    - miss_cnt += 1.
  - When miss_cnt reaches unlock_threshold_p: go to SEEK, set match_cnt = 0, and deassert locked_o the next cycle.
  - The word that triggers unlock is still counted as an error.
- Cycles with no accepted word: state and expected_r hold; err_v_o = 0.
- err_mask_o holds its value until the next erroneous word or until reset.
- Counters saturate at all-ones and never wrap.
- clear_i has priority over an increment in the same cycle: counters read 0 afterwards. err_v_o and err_mask_o still update for that word.
- Reset asserted mid-operation: immediate return to reset values regardless of state or handshake.

Optional Feature:
- Macro: BSG_LFSR_CHECKER_BIT_ERR_EN.
- Defined: bit_err_count_o exists.
  - On each mismatch in LOCKED it adds popcount(data_i ^ expected_r), saturating at all-ones.
  - clear_i and reset zero it.
- Not defined: the port is absent, and no popcount logic or counter is built.

Test Plan:
- Lock: reset, then words 0x0001, 0xB400, 0x5A00, 0x2D00 on consecutive cycles -> locked_o rises the cycle after 0x2D00; err_count_o = 0; word_count_o = 0.
- Error injection: after lock, send 0x1683 (expected 0x1680) -> err_v_o high for one cycle; err_mask_o = 0x0003; err_count_o = 1; word_count_o = 1; bit_err_count_o = 2 with the macro; the next correct word 0x0B40 gives no error.
- Unlock: after lock, send 3 consecutive wrong words -> locked_o falls the cycle after the third; err_count_o = 3; a new seed sequence then relocks after 4 words.
- Seek robustness: in SEEK, send 0x0001, 0x0000, 0xB400, 0x5A00, 0x2D00, 0x1680 -> the zero word restarts the count; lock occurs only after 0x1680.
- Saturation and clear: cnt_width_p = 2 with 5 erroneous words (unlock_threshold_p = 8) -> err_count_o stays at 3. clear_i asserted together with an error word -> err_count_o = 0 while err_v_o still pulses.
- Reset mid-lock: assert reset_i asynchronously between clock edges while locked -> locked_o, all counters and err_mask_o go to 0 immediately; ready_o is 0 until release.
